// File: rtl/clk_mon_pkg.sv
// rtl/clk_mon_pkg.sv - shared FSM state type and default parameters for the clock activity monitor
package clk_mon_pkg;

    localparam int DEF_WINDOW    = 1024;
    localparam int DEF_CNT_W     = 16;
    localparam int DEF_STUCK_LIM = 64;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARM     = 2'd1,
        ST_MEASURE = 2'd2,
        ST_REPORT  = 2'd3
    } mon_state_t;

endpackage

// File: rtl/sync_edge_det.sv
// rtl/sync_edge_det.sv - two-flop synchronizer, delay flop and rising-edge detect for a foreign clock
module sync_edge_det (
    input  logic clk,
    input  logic rst_n,
    input  logic i_async,
    output logic o_level,
    output logic o_change,
    output logic o_rise
);

    logic r_s1;
    logic r_s2;
    logic r_s3;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            r_s1 <= i_async;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    // r_s1 may go metastable; only r_s2 onward is consumed
    assign o_level  = r_s2;
    assign o_change = r_s2 ^ r_s3;
    assign o_rise   = r_s2 & ~r_s3;

endmodule

// File: rtl/clk_activity_monitor.sv
// rtl/clk_activity_monitor.sv - counts rising edges of a foreign clock over a fixed gate and flags a stuck input
module clk_activity_monitor
    import clk_mon_pkg::*;
#(
    parameter int WINDOW    = DEF_WINDOW,
    parameter int CNT_W     = DEF_CNT_W,
    parameter int STUCK_LIM = DEF_STUCK_LIM
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             mon_clk_in,
    input  logic             start,
    input  logic             cont,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] edge_count,
    output logic             overflow,
    output logic             mon_stuck,
    output logic             mon_level
);

    localparam int WIN_W = $clog2(WINDOW);
    localparam int STK_W = $clog2(STUCK_LIM + 1);

    localparam logic [WIN_W-1:0] WIN_LOAD = WIN_W'(WINDOW - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [STK_W-1:0] STK_MAX  = STK_W'(STUCK_LIM);

    mon_state_t       r_state;
    mon_state_t       w_next;
    logic [WIN_W-1:0] r_win;
    logic [CNT_W-1:0] r_acc;
    logic             r_acc_ovf;
    logic [CNT_W-1:0] r_edge_count;
    logic             r_overflow;
    logic             r_done;
    logic [STK_W-1:0] r_stuck_cnt;
    logic             w_level;
    logic             w_change;
    logic             w_rise;

    sync_edge_det u_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_async  (mon_clk_in),
        .o_level  (w_level),
        .o_change (w_change),
        .o_rise   (w_rise)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // start is only looked at in IDLE, so pulses while busy fall through
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:    if (start) w_next = ST_ARM;
            ST_ARM:     w_next = ST_MEASURE;
            ST_MEASURE: if (r_win == '0) w_next = ST_REPORT;
            ST_REPORT:  w_next = cont ? ST_ARM : ST_IDLE;
            default:    w_next = ST_IDLE;
        endcase
    end

    // The final MEASURE cycle still counts its edge, giving exactly WINDOW sampled cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_win        <= '0;
            r_acc        <= '0;
            r_acc_ovf    <= 1'b0;
            r_edge_count <= '0;
            r_overflow   <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_ARM: begin
                    r_acc     <= '0;
                    r_acc_ovf <= 1'b0;
                    r_win     <= WIN_LOAD;
                end
                ST_MEASURE: begin
                    if (r_win != '0) begin
                        r_win <= r_win - 1'b1;
                    end
                    if (w_rise) begin
                        if (r_acc == CNT_MAX) begin
                            r_acc_ovf <= 1'b1;
                        end else begin
                            r_acc <= r_acc + 1'b1;
                        end
                    end
                end
                ST_REPORT: begin
                    r_edge_count <= r_acc;
                    r_overflow   <= r_acc_ovf;
                    r_done       <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stuck_cnt <= '0;
        end else if (w_change) begin
            r_stuck_cnt <= '0;
        end else if (r_stuck_cnt != STK_MAX) begin
            r_stuck_cnt <= r_stuck_cnt + 1'b1;
        end
    end

    assign busy       = (r_state != ST_IDLE);
    assign done       = r_done;
    assign edge_count = r_edge_count;
    assign overflow   = r_overflow;
    assign mon_stuck  = (r_stuck_cnt == STK_MAX);
    assign mon_level  = w_level;

endmodule

// File: tb/tb_clk_activity_monitor.sv
// tb/tb_clk_activity_monitor.sv - scoreboard bench for clk_activity_monitor
module tb_clk_activity_monitor;

    localparam int W   = 100;
    localparam int CW  = 16;
    localparam int LIM = 16;
    localparam int NW  = 8192;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          mon_clk_in;
    logic          start;
    logic          cont;
    logic          busy;
    logic          done;
    logic [CW-1:0] edge_count;
    logic          overflow;
    logic          mon_stuck;
    logic          mon_level;
    logic          busy4;
    logic          done4;
    logic [3:0]    edge_count4;
    logic          overflow4;
    logic          mon_stuck4;
    logic          mon_level4;

    typedef struct {
        int cnt;
        int done_edge;
    } exp_t;

    exp_t sb[$];
    bit   wave [0:NW-1];
    int   edge_n = 0;
    int   r0 = 0;
    int   checks = 0;
    int   errors = 0;
    int   last_cnt = 0;
    int   last_ovf = 0;
    int   last_cnt4 = 0;
    int   last_ovf4 = 0;

    clk_activity_monitor #(.WINDOW(W), .CNT_W(CW), .STUCK_LIM(LIM)) dut (
        .clk(clk), .rst_n(rst_n), .mon_clk_in(mon_clk_in), .start(start), .cont(cont),
        .busy(busy), .done(done), .edge_count(edge_count), .overflow(overflow),
        .mon_stuck(mon_stuck), .mon_level(mon_level)
    );

    clk_activity_monitor #(.WINDOW(W), .CNT_W(4), .STUCK_LIM(LIM)) dut4 (
        .clk(clk), .rst_n(rst_n), .mon_clk_in(mon_clk_in), .start(start), .cont(cont),
        .busy(busy4), .done(done4), .edge_count(edge_count4), .overflow(overflow4),
        .mon_stuck(mon_stuck4), .mon_level(mon_level4)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at edge %0d: got %0d expected %0d", name, edge_n, act, exp);
        end
    endtask

    // Rising edges of the sampled input inside the gate: samples a .. a+W-1
    function automatic int exp_count(input int a);
        int c = 0;
        for (int m = a; m < a + W; m++) begin
            if (wave[m] && !wave[m-1]) c++;
        end
        return c;
    endfunction

    function automatic int stuck_model(input int n);
        for (int k = n - 2 - LIM; k < n - 2; k++) begin
            if (wave[k] != wave[k+1]) return 0;
        end
        return 1;
    endfunction

    task automatic fill(input int from, input int len, input int mode, input int p);
        bit lvl;
        int i;
        int run;
        if (mode == 0) begin
            for (int k = 0; k < len; k++) wave[from+k] = p[0];
        end else if (mode == 1) begin
            for (int k = 0; k < len; k++) wave[from+k] = ((k % p) < (p / 2));
        end else begin
            lvl = wave[from-1];
            i   = from;
            while (i < from + len) begin
                lvl = !lvl;
                run = $urandom_range(5, 2);
                for (int r = 0; r < run && i < from + len; r++) begin
                    wave[i] = lvl;
                    i++;
                end
            end
        end
    endtask

    task automatic push_exp(input int a);
        exp_t e;
        e.cnt       = exp_count(a);
        e.done_edge = a + W + 2;
        sb.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_windows(input int k, input bit spurious);
        int a;
        int tot;
        a   = edge_n + 1;
        tot = k * (W + 2);
        for (int i = 0; i < k; i++) push_exp(a + i * (W + 2));
        start = 1'b1;
        cont  = (k > 1);
        step();
        chk("busy_after_start", int'(busy), 1);
        for (int t = 1; t <= tot + 2; t++) begin
            start = spurious && (t % 37 == 0) && (t < tot - 2);
            if (k > 1 && t == (k - 1) * (W + 2) + W / 2) cont = 1'b0;
            step();
        end
        start = 1'b0;
        cont  = 1'b0;
        chk("busy_after_last_done", int'(busy), 0);
        chk("sb_drained", sb.size(), 0);
    endtask

    // Input driver: the value for edge n is wave[n]
    initial begin
        mon_clk_in = 1'b0;
        forever begin
            @(posedge clk);
            edge_n++;
            #1;
            mon_clk_in = wave[edge_n+1];
        end
    end

    // Output monitor / scoreboard
    always @(negedge clk) begin
        exp_t e;
        int   due;
        if (!rst_n) begin
            chk("rst_busy", int'(busy), 0);
            chk("rst_done", int'(done), 0);
            chk("rst_edge_count", int'(edge_count), 0);
            chk("rst_overflow", int'(overflow), 0);
            chk("rst_mon_stuck", int'(mon_stuck), 0);
            chk("rst_mon_level", int'(mon_level), 0);
            chk("rst_done4", int'(done4), 0);
            chk("rst_edge_count4", int'(edge_count4), 0);
            last_cnt  = 0;
            last_ovf  = 0;
            last_cnt4 = 0;
            last_ovf4 = 0;
        end else begin
            due = (sb.size() > 0 && sb[0].done_edge == edge_n) ? 1 : 0;
            chk("done4_timing", int'(done4), due);
            if (done) begin
                if (sb.size() == 0) begin
                    chk("unexpected_done", int'(done), 0);
                end else begin
                    e = sb.pop_front();
                    chk("done_edge", edge_n, e.done_edge);
                    chk("edge_count", int'(edge_count), e.cnt);
                    chk("overflow", int'(overflow), (e.cnt > (2**CW - 1)) ? 1 : 0);
                    chk("edge_count4", int'(edge_count4), (e.cnt > 15) ? 15 : e.cnt);
                    chk("overflow4", int'(overflow4), (e.cnt > 15) ? 1 : 0);
                    last_cnt  = e.cnt;
                    last_ovf  = 0;
                    last_cnt4 = (e.cnt > 15) ? 15 : e.cnt;
                    last_ovf4 = (e.cnt > 15) ? 1 : 0;
                end
            end else if (sb.size() > 0 && edge_n >= sb[0].done_edge) begin
                e = sb.pop_front();
                chk("done_missing", int'(done), 1);
            end
            chk("hold_edge_count", int'(edge_count), last_cnt);
            chk("hold_overflow", int'(overflow), last_ovf);
            chk("hold_edge_count4", int'(edge_count4), last_cnt4);
            chk("hold_overflow4", int'(overflow4), last_ovf4);
            if (edge_n >= r0 + LIM + 4) begin
                chk("mon_level", int'(mon_level), int'(wave[edge_n-1]));
                chk("mon_stuck", int'(mon_stuck), stuck_model(edge_n));
                chk("mon_stuck4", int'(mon_stuck4), stuck_model(edge_n));
                chk("mon_level4", int'(mon_level4), int'(wave[edge_n-1]));
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached at edge %0d", edge_n);
        $fatal(1, "watchdog");
    end

    initial begin
        int a;
        int m;
        rst_n = 1'b0;
        start = 1'b0;
        cont  = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;
        r0    = edge_n + 1;
        repeat (2) step();

        // clk/4 square wave, one window: about 25 edges; 4-bit copy saturates
        fill(edge_n + 2, 3 * W, 1, 4);
        run_windows(1, 1'b0);

        // Random high/low runs of 2..5 cycles, with start pulses while busy
        fill(edge_n + 2, 4 * W, 2, 0);
        run_windows(1, 1'b1);
        run_windows(1, 1'b1);

        // clk/8 continuous mode, cont dropped during the last window
        fill(edge_n + 2, 4 * W, 1, 8);
        run_windows(3, 1'b1);

        // Stuck high, one short low pulse, then a window with no activity
        fill(edge_n + 2, 4 * W, 0, 1);
        repeat (60) step();
        chk("stuck_set", int'(mon_stuck), 1);
        fill(edge_n + 2, 2, 0, 0);
        fill(edge_n + 4, 4 * W, 0, 1);
        repeat (4) step();
        chk("stuck_cleared", int'(mon_stuck), 0);
        repeat (30) step();
        run_windows(1, 1'b0);

        // Reset in mid-MEASURE, then start on the first edge after release
        fill(edge_n + 2, 3 * W, 2, 0);
        a = edge_n + 1;
        push_exp(a);
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (50) step();
        rst_n = 1'b0;
        sb.delete();
        m = edge_n;
        fill(m + 2, 12, 0, 0);
        fill(m + 14, 4 * W, 2, 0);
        repeat (3) step();
        rst_n = 1'b1;
        start = 1'b1;
        a     = edge_n + 1;
        r0    = a;
        push_exp(a);
        step();
        start = 1'b0;
        chk("busy_after_reset_start", int'(busy), 1);
        repeat (W + 6) step();
        chk("busy_idle_end", int'(busy), 0);
        chk("sb_empty_end", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/clk_activity_monitor.md
CLK_ACTIVITY_MONITOR -- requirements
Module: clk_activity_monitor

Interface
REQ-001 The block SHALL have parameter WINDOW, default 1024, giving the measurement gate length in clk cycles (legal range 2..65535).
REQ-002 The block SHALL have parameter CNT_W, default 16, giving the edge-count width.
REQ-003 The block SHALL have parameter STUCK_LIM, default 64, giving the clk cycles without a level change before the monitored signal is declared stuck.
REQ-004 clk  input  1  the only clock; all state is in this domain.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 mon_clk_in  input  1  foreign clock sampled as asynchronous data, never used as a clock, reset or control.
REQ-007 start  input  1  single-cycle request to begin a measurement.
REQ-008 cont  input  1  when 1 at REPORT, the next measurement re-arms automatically.
REQ-009 busy  output  1  high in ARM, MEASURE and REPORT.
REQ-010 done  output  1  one-cycle pulse when a result is published.
REQ-011 edge_count  output  CNT_W  rising edges of mon_clk_in counted in the last completed window.
REQ-012 overflow  output  1  the last window saturated the counter.
REQ-013 mon_stuck  output  1  mon_clk_in has not toggled for STUCK_LIM cycles.
REQ-014 mon_level  output  1  synchronized level of mon_clk_in.

Function
REQ-015 mon_clk_in SHALL pass through a two-flop synchronizer (s1, s2) and a third flop s3; rising edge = s2 & ~s3; latency from the input to s2 is 2 clk cycles.
REQ-016 mon_level SHALL equal s2.
REQ-017 The FSM SHALL have states IDLE, ARM, MEASURE and REPORT.
REQ-018 IDLE: start=1 -> ARM; otherwise remain.
REQ-019 ARM (1 cycle): clear the accumulator and the overflow flag, load the window counter with WINDOW-1 -> MEASURE.
REQ-020 MEASURE: each cycle add 1 to the accumulator on a rising edge and decrement the window counter; when the counter is 0 (that cycle's edge included) -> REPORT; the window is exactly WINDOW cycles.
REQ-021 REPORT (1 cycle): load edge_count and overflow from the accumulator, assert done; cont=1 -> ARM, else -> IDLE.
REQ-022 The accumulator SHALL saturate at 2^CNT_W-1 and set the internal overflow flag.
REQ-023 start SHALL be ignored while busy=1.
REQ-024 Deasserting cont during MEASURE SHALL complete the current window, and the decision SHALL be taken from cont sampled in REPORT.
REQ-025 edge_count and overflow SHALL hold their values between REPORT cycles.
REQ-026 The stuck counter SHALL reset to 0 on any s2 != s3 cycle and otherwise increment, saturating at STUCK_LIM; mon_stuck = (counter == STUCK_LIM); this runs independently of the FSM.
REQ-027 Counting accuracy is guaranteed for f_mon <= f_clk/4 with mon_clk_in high and low time each >= 2 clk periods; higher rates produce undefined counts but no illegal state.

Reset
REQ-028 While rst_n=0, state SHALL be IDLE, s1/s2/s3 = 0, all counters = 0, and busy, done, edge_count, overflow, mon_stuck and mon_level = 0.
REQ-029 Reset during MEASURE SHALL abandon the window with no done pulse and no change to edge_count after release.
REQ-030 After rst_n rises, start SHALL be accepted on the first clk edge.

Structure
REQ-031 Package clk_mon_pkg SHALL hold the FSM state enum and the default WINDOW/CNT_W/STUCK_LIM constants.
REQ-032 Sub-module sync_edge_det SHALL implement the synchronizer, s3 and the rising-edge output; clk_activity_monitor instantiates it once.

Verification
REQ-033 WINDOW=100, mon_clk_in = clk/4 square wave, start pulse -> done after 102 cycles, edge_count = 25 +/- 1, overflow=0.
REQ-034 CNT_W=4, WINDOW=100, mon_clk_in = clk/4 -> edge_count = 15, overflow=1.
REQ-035 mon_clk_in held at 1 -> mon_stuck=1 exactly STUCK_LIM cycles after s2 settles; one toggle clears it within 3 cycles; a subsequent window gives edge_count=0.
REQ-036 cont=1 with a clk/8 input -> back-to-back done pulses every WINDOW+2 cycles; start pulses while busy are ignored.
REQ-037 rst_n pulsed low at mid-MEASURE -> all outputs 0, no done; a new start then gives a correct full-window count.
REQ-038 start asserted in the first cycle after rst_n release -> busy=1 on the next cycle.
